// File: rtl/beep_det_pkg.sv
// Shared types and defaults for the beep detector: FSM state encoding,
// default thresholds and the debounce counter width.
package beep_det_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ON_PEND  = 2'd1,
    ON       = 2'd2,
    OFF_PEND = 2'd3
  } state_t;

  localparam int         WIN_LOG2_DEF = 6;
  localparam logic [7:0] TH_ON_DEF    = 8'd64;
  localparam logic [7:0] TH_OFF_DEF   = 8'd40;
  localparam int         DEB_DEF      = 3;
  localparam int         LEN_W_DEF    = 16;

  // run and gap counters never exceed DEB, which is limited to 1..15
  localparam int DEB_W = 4;

endpackage

// File: rtl/beep_detector_window_p2p.sv
// Windowed peak-to-peak envelope: tracks max/min over 2^WIN_LOG2 valid
// samples and publishes max-min with a one-cycle strobe at each window end.
module window_p2p #(
  parameter int WIN_LOG2 = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  output logic [7:0] amp,
  output logic       amp_valid
);

  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [7:0]          max_q, max_d;
  logic [7:0]          min_q, min_d;
  logic [7:0]          amp_q, amp_d;
  logic                amp_valid_q, amp_valid_d;

  always_comb begin
    cnt_d       = cnt_q;
    max_d       = max_q;
    min_d       = min_q;
    amp_d       = amp_q;
    amp_valid_d = 1'b0;
    if (sample_valid) begin
      if (cnt_q == '0) begin
        max_d = sample;
        min_d = sample;
      end else begin
        if (sample > max_q) max_d = sample;
        if (sample < min_q) min_d = sample;
      end
      // counter wraps to 0 on its own after the last sample of the window
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        amp_d       = max_d - min_d;
        amp_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      max_q       <= '0;
      min_q       <= '0;
      amp_q       <= '0;
      amp_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      min_q       <= min_d;
      amp_q       <= amp_d;
      amp_valid_q <= amp_valid_d;
    end
  end

  assign amp       = amp_q;
  assign amp_valid = amp_valid_q;

endmodule

// File: rtl/beep_detector.sv
// Tone-presence detector: hysteresis plus debounce on windowed amplitude,
// emitting a one-cycle pulse_done with the beep length in windows.
module beep_detector
  import beep_det_pkg::*;
#(
  parameter int         WIN_LOG2 = WIN_LOG2_DEF,
  parameter logic [7:0] TH_ON    = TH_ON_DEF,
  parameter logic [7:0] TH_OFF   = TH_OFF_DEF,
  parameter int         DEB      = DEB_DEF,
  parameter int         LEN_W    = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [7:0]       sample,
  output logic [7:0]       amp,
  output logic             amp_valid,
  output logic             beep_on,
  output logic             pulse_done,
  output logic [LEN_W-1:0] pulse_len
);

  localparam logic [DEB_W-1:0] DEB_V      = DEB_W'(DEB);
  localparam bit               DEB_IS_ONE = (DEB == 1);
  localparam logic [LEN_W-1:0] LEN_MAX    = '1;
  localparam int               SUM_W      = LEN_W + DEB_W + 1;

  window_p2p #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_window (
    .clk          (clk),
    .rst_n        (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .amp          (amp),
    .amp_valid    (amp_valid)
  );

  state_t           state_q, state_d;
  logic [DEB_W-1:0] run_q, run_d;
  logic [DEB_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] pulse_len_q, pulse_len_d;
  logic             pulse_done_q, pulse_done_d;
  logic             beep_on_q, beep_on_d;

  logic             hi, lo, confirm_off;
  logic [DEB_W-1:0] run_nxt, gap_nxt;
  logic [LEN_W-1:0] len_inc, len_rejoin;
  logic [SUM_W-1:0] rejoin_sum;

  assign hi      = (amp >= TH_ON);
  assign lo      = (amp < TH_OFF);
  assign run_nxt = run_q + 1'b1;
  assign gap_nxt = gap_q + 1'b1;
  assign len_inc = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;

  // a broken off-run folds its gap windows back into the beep length
  assign rejoin_sum = SUM_W'(len_q) + SUM_W'(gap_q) + SUM_W'(1);
  assign len_rejoin = (rejoin_sum > SUM_W'(LEN_MAX)) ? LEN_MAX : rejoin_sum[LEN_W-1:0];

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    gap_d        = gap_q;
    len_d        = len_q;
    pulse_len_d  = pulse_len_q;
    pulse_done_d = 1'b0;
    confirm_off  = 1'b0;
    if (amp_valid) begin
      case (state_q)
        IDLE: begin
          if (hi) begin
            run_d   = DEB_W'(1);
            len_d   = LEN_W'(1);
            state_d = DEB_IS_ONE ? ON : ON_PEND;
          end
        end
        ON_PEND: begin
          if (hi) begin
            run_d = run_nxt;
            len_d = len_inc;
            if (run_nxt == DEB_V) state_d = ON;
          end else begin
            state_d = IDLE;
          end
        end
        ON: begin
          if (lo) begin
            gap_d = DEB_W'(1);
            if (DEB_IS_ONE) confirm_off = 1'b1;
            else            state_d     = OFF_PEND;
          end else begin
            len_d = len_inc;
          end
        end
        OFF_PEND: begin
          if (lo) begin
            gap_d = gap_nxt;
            if (gap_nxt == DEB_V) confirm_off = 1'b1;
          end else begin
            len_d   = len_rejoin;
            state_d = ON;
          end
        end
        default: state_d = IDLE;
      endcase
      if (confirm_off) begin
        state_d      = IDLE;
        pulse_done_d = 1'b1;
        pulse_len_d  = len_q;
      end
    end
    beep_on_d = (state_d == ON) || (state_d == OFF_PEND);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      run_q        <= '0;
      gap_q        <= '0;
      len_q        <= '0;
      pulse_len_q  <= '0;
      pulse_done_q <= 1'b0;
      beep_on_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      gap_q        <= gap_d;
      len_q        <= len_d;
      pulse_len_q  <= pulse_len_d;
      pulse_done_q <= pulse_done_d;
      beep_on_q    <= beep_on_d;
    end
  end

  assign beep_on    = beep_on_q;
  assign pulse_done = pulse_done_q;
  assign pulse_len  = pulse_len_q;

endmodule

// File: tb/tb_beep_detector.sv
// Randomised and directed bench for beep_detector, checked against a
// window-list model of tone detection kept in the bench.
`timescale 1ns/1ps
module tb_beep_detector;

  localparam int WIN_LOG2 = 6;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int TH_ON    = 64;
  localparam int TH_OFF   = 40;
  localparam int DEB      = 3;
  localparam int LEN_W    = 6;
  localparam int LEN_MAX  = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_valid = 1'b0;
  logic [7:0]       sample = 8'd0;
  logic [7:0]       amp;
  logic             amp_valid;
  logic             beep_on;
  logic             pulse_done;
  logic [LEN_W-1:0] pulse_len;

  beep_detector #(
    .WIN_LOG2 (WIN_LOG2),
    .TH_ON    (8'd64),
    .TH_OFF   (8'd40),
    .DEB      (DEB),
    .LEN_W    (LEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .amp          (amp),
    .amp_valid    (amp_valid),
    .beep_on      (beep_on),
    .pulse_done   (pulse_done),
    .pulse_len    (pulse_len)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int gcyc   = 0;

  int amps[$];
  int win_cnt = 0, wmax = 0, wmin = 0;
  bit pend_av = 1'b0;
  int pend_amp = 0;
  bit exp_on = 1'b0, exp_pulse = 1'b0;
  int exp_len = 0;
  bit fsm_upd = 1'b0, nxt_on = 1'b0, nxt_pulse = 1'b0;
  int nxt_len = 0;

  int rise_cyc = -1, fall_cyc = -1, pulse_cyc = -1, pulse_seen_len = -1;
  int pulse_cnt = 0;
  bit prev_on = 1'b0;

  // Scan the list of window amplitudes since reset: a beep starts at DEB
  // consecutive hi windows and ends at the first run of DEB consecutive lo
  // windows; its length is the span from the first hi to the window before
  // the confirming lo run.
  function automatic void model_eval(output bit on, output bit pulse, output int plen);
    int n, i, m, k, start, endw;
    bit found, all_lo;
    n = amps.size(); i = 0; on = 0; pulse = 0; plen = 0;
    while (i < n) begin
      m = 0;
      while (m < DEB && i + m < n && amps[i+m] >= TH_ON) m++;
      if (m < DEB) begin
        if (i + m == n) i = n;
        else i = i + 1;
      end else begin
        start = i; k = i + DEB; found = 0;
        while (!found && k + DEB <= n) begin
          all_lo = 1;
          for (int j = 0; j < DEB; j++) if (amps[k+j] >= TH_OFF) all_lo = 0;
          if (all_lo) found = 1;
          else k++;
        end
        if (!found) begin
          on = 1; i = n;
        end else begin
          endw  = k + DEB - 1;
          plen  = (k - start > LEN_MAX) ? LEN_MAX : k - start;
          pulse = (endw == n - 1);
          i     = endw + 1;
        end
      end
    end
  endfunction

  // Drive windows of amplitude a (base<0: random offset and random interior
  // samples) and check every cycle. nwin<0 runs until max_cyc is reached.
  task automatic drive(input int nwin, input int a, input int base,
                       input int gap_pct, input int max_cyc);
    int done = 0, c = 0, lo_v = 0, s;
    while ((nwin < 0 || done < nwin) && (max_cyc == 0 || c < max_cyc)) begin
      sample_valid = ($urandom_range(99) >= gap_pct);
      if (win_cnt == 0) lo_v = (base < 0) ? int'($urandom_range(255 - a)) : base;
      if (win_cnt == 0)      s = lo_v;
      else if (win_cnt == 1) s = lo_v + a;
      else if (base < 0)     s = lo_v + int'($urandom_range(a));
      else                   s = (win_cnt % 2 == 1) ? lo_v + a : lo_v;
      sample = 8'(s);

      @(negedge clk);
      if (fsm_upd) begin
        exp_on = nxt_on; exp_pulse = nxt_pulse; exp_len = nxt_len; fsm_upd = 0;
      end else begin
        exp_pulse = 0;
      end
      if (errors < 40) begin
        checks++;
        if (amp_valid !== pend_av)
          $display("FAIL amp_valid cyc=%0d: got %0b expected %0b", gcyc, amp_valid, pend_av);
        if (pend_av) begin
          checks++;
          if (amp !== 8'(pend_amp))
            $display("FAIL amp cyc=%0d: got %0d expected %0d", gcyc, amp, pend_amp);
        end
        checks++;
        if (beep_on !== exp_on)
          $display("FAIL beep_on cyc=%0d: got %0b expected %0b", gcyc, beep_on, exp_on);
        checks++;
        if (pulse_done !== exp_pulse)
          $display("FAIL pulse_done cyc=%0d: got %0b expected %0b", gcyc, pulse_done, exp_pulse);
        checks++;
        if (pulse_len !== LEN_W'(exp_len))
          $display("FAIL pulse_len cyc=%0d: got %0d expected %0d", gcyc, pulse_len, exp_len);
        if ((amp_valid !== pend_av) || (pend_av && amp !== 8'(pend_amp)) ||
            (beep_on !== exp_on) || (pulse_done !== exp_pulse) ||
            (pulse_len !== LEN_W'(exp_len)))
          errors++;
      end
      if (beep_on === 1'b1 && !prev_on) rise_cyc = gcyc;
      if (beep_on === 1'b0 && prev_on)  fall_cyc = gcyc;
      if (pulse_done === 1'b1) begin
        pulse_cyc = gcyc; pulse_seen_len = int'(pulse_len); pulse_cnt++;
      end
      prev_on = (beep_on === 1'b1);

      if (pend_av) begin
        amps.push_back(pend_amp);
        model_eval(nxt_on, nxt_pulse, nxt_len);
        fsm_upd = 1;
        $display("win %0d cyc=%0d amp=%0d -> beep_on=%0b pulse=%0b len=%0d",
                 amps.size() - 1, gcyc, pend_amp, nxt_on, nxt_pulse, nxt_len);
      end
      pend_av = 0;
      if (sample_valid) begin
        if (win_cnt == 0) begin
          wmax = s; wmin = s;
        end else begin
          if (s > wmax) wmax = s;
          if (s < wmin) wmin = s;
        end
        win_cnt++;
        if (win_cnt == WIN) begin
          pend_av = 1; pend_amp = wmax - wmin; win_cnt = 0; done++;
        end
      end
      @(posedge clk); #1;
      gcyc++; c++;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({amp, amp_valid, beep_on, pulse_done, pulse_len} !== '0) begin
      errors++;
      $display("FAIL reset_values: got amp=%0d av=%0b on=%0b pd=%0b len=%0d expected all 0",
               amp, amp_valid, beep_on, pulse_done, pulse_len);
    end
    rst = 1'b1;
  endtask

  task automatic test_constant();
    rise_cyc = -1;
    drive(4, 0, 128, 0, 0);
    drive(-1, 0, 128, 100, 3);
    checks++;
    if (rise_cyc != -1) begin
      errors++;
      $display("FAIL const_no_beep: got rise at %0d expected none", rise_cyc);
    end
  endtask

  task automatic test_alternating();
    int start;
    rise_cyc = -1; fall_cyc = -1; pulse_cyc = -1;
    start = gcyc;
    drive(10, 255, 0, 0, 0);
    drive(3, 0, 128, 0, 0);
    drive(-1, 0, 128, 100, 3);
    checks++;
    if (rise_cyc - start != 193) begin
      errors++;
      $display("FAIL alt_rise_cycle: got %0d expected 193", rise_cyc - start);
    end
    checks++;
    if (fall_cyc - start != 833 || pulse_cyc - start != 833) begin
      errors++;
      $display("FAIL alt_end_cycle: got fall %0d pulse %0d expected 833", fall_cyc - start, pulse_cyc - start);
    end
    checks++;
    if (pulse_seen_len != 10) begin
      errors++;
      $display("FAIL alt_pulse_len: got %0d expected 10", pulse_seen_len);
    end
  endtask

  task automatic test_abort();
    int p0;
    rise_cyc = -1; p0 = pulse_cnt;
    drive(2, 80, 0, 0, 0);
    drive(2, 0, 0, 0, 0);
    drive(-1, 0, 128, 100, 3);
    checks++;
    if (rise_cyc != -1 || pulse_cnt != p0) begin
      errors++;
      $display("FAIL on_pend_abort: got rise %0d pulses %0d expected none", rise_cyc, pulse_cnt - p0);
    end
  endtask

  task automatic test_gap_in_beep();
    int p0;
    p0 = pulse_cnt;
    drive(4, 255, 0, 0, 0);
    drive(2, 0, 128, 0, 0);
    drive(3, 255, 0, 0, 0);
    drive(3, 0, 128, 0, 0);
    drive(-1, 0, 128, 100, 3);
    checks++;
    if (pulse_cnt - p0 != 1 || pulse_seen_len != 9) begin
      errors++;
      $display("FAIL gap_continuity: got %0d pulses len %0d expected 1 pulse len 9", pulse_cnt - p0, pulse_seen_len);
    end
  endtask

  task automatic test_saturation();
    drive(65, 255, 0, 0, 0);
    drive(2, 0, 128, 0, 0);
    drive(5, 255, 0, 0, 0);
    drive(3, 0, 128, 0, 0);
    drive(-1, 0, 128, 100, 3);
    checks++;
    if (pulse_seen_len != LEN_MAX) begin
      errors++;
      $display("FAIL len_saturate: got %0d expected %0d", pulse_seen_len, LEN_MAX);
    end
  endtask

  task automatic test_random();
    int amp_tab[9] = '{0, 20, 39, 40, 50, 63, 64, 100, 255};
    for (int seg = 0; seg < 40; seg++)
      drive(int'($urandom_range(5, 1)), amp_tab[$urandom_range(8)], -1, 15, 0);
    drive(3, 0, -1, 15, 0);
    drive(-1, 0, 128, 100, 3);
  endtask

  task automatic test_reset_mid_beep();
    int p0;
    drive(4, 255, 0, 0, 0);
    drive(-1, 255, 0, 0, 20);
    checks++;
    if (beep_on !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_beep_on: got %0b expected 1", beep_on);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({amp, amp_valid, beep_on, pulse_done, pulse_len} !== '0) begin
      errors++;
      $display("FAIL async_reset: got amp=%0d av=%0b on=%0b pd=%0b len=%0d expected all 0",
               amp, amp_valid, beep_on, pulse_done, pulse_len);
    end
    amps.delete();
    win_cnt = 0; pend_av = 0; fsm_upd = 0;
    exp_on = 0; exp_pulse = 0; exp_len = 0; prev_on = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    p0 = pulse_cnt;
    drive(4, 0, 128, 0, 0);
    drive(-1, 0, 128, 100, 3);
    checks++;
    if (pulse_cnt != p0) begin
      errors++;
      $display("FAIL no_pulse_after_reset: got %0d pulses expected 0", pulse_cnt - p0);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_alternating();
    test_abort();
    test_gap_in_beep();
    test_saturation();
    test_random();
    test_reset_mid_beep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
